// File: rtl/output_psum_writer_if.sv
// Memory write stream from the psum writer: valid/ready with address and data.
// Master holds addr/data stable while valid is high and ready is low.
interface output_psum_writer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/output_psum_writer.sv
// Psum output stage: buffers pushed psums in a FIFO and streams them to sequential addresses.
// Push-to-valid latency 1 cycle, no bypass; wr_ready low stalls the stream, pushes to a full FIFO drop and set overflow.

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit tells full from empty when the indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end
endmodule

module output_psum_writer #(
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH           = 32,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                            CLK,
   input  logic                            RESETN,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           output_base_addr,
   input  logic [15:0]                     num_words,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0] psum_in,
   input  logic                            out_storage_wr_en,
   output_psum_writer_if.master            wr,
   output logic                            fifo_full,
   output logic                            overflow,
   output logic                            done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [ADDR_WIDTH-1:0]           base_q;
   logic [15:0]                     len_q;
   logic [15:0]                     wr_cnt;
   logic                            fifo_empty;
   logic                            pop;
   logic                            push_req;
   logic                            push_acc;
   logic                            last_hs;
   logic [C_M00_AXI_DATA_WIDTH-1:0] head_dat;

   assign wr.wr_valid = (state == RUN) && !fifo_empty;
   assign wr.wr_data  = head_dat;
   assign wr.wr_addr  = base_q + (ADDR_WIDTH'(wr_cnt) << 2);

   assign pop      = wr.wr_valid && wr.wr_ready;
   assign push_req = (state == RUN) && out_storage_wr_en;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign push_acc = push_req && (!fifo_full || pop);
   assign last_hs  = pop && ((wr_cnt + 16'd1) == len_q);
   assign done     = (state == DONE);

   sync_fifo #(
      .WIDTH (C_M00_AXI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .flush    (start),
      .push     (push_acc),
      .push_dat (psum_in),
      .pop      (pop),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN: begin
               if ((len_q == 16'd0) || last_hs) begin
                  state_nxt = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         base_q   <= '0;
         len_q    <= '0;
         wr_cnt   <= '0;
         overflow <= 1'b0;
      end else if (start) begin
         base_q   <= output_base_addr;
         len_q    <= num_words;
         wr_cnt   <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
         if (push_req && !push_acc) begin
            overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_output_psum_writer.sv
// Bench for output_psum_writer: vector table, directed corner sequences and random traffic vs a queue model.
module tb_output_psum_writer;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base = '0;
   logic [15:0] num_words = '0;
   logic [31:0] psum_in = '0;
   logic        out_storage_wr_en = 1'b0;
   logic        fifo_full;
   logic        overflow;
   logic        done;

   output_psum_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wr_if ();

   output_psum_writer #(
      .C_M00_AXI_DATA_WIDTH (DW),
      .ADDR_WIDTH           (AW),
      .FIFO_DEPTH           (DEPTH)
   ) dut (
      .CLK               (CLK),
      .RESETN            (RESETN),
      .start             (start),
      .output_base_addr  (base),
      .num_words         (num_words),
      .psum_in           (psum_in),
      .out_storage_wr_en (out_storage_wr_en),
      .wr                (wr_if),
      .fifo_full         (fifo_full),
      .overflow          (overflow),
      .done              (done)
   );

   always #5 CLK = ~CLK;

   int unsigned total = 0;
   int unsigned bad = 0;

   // Reference model: a queue of buffered words plus the run bookkeeping.
   logic [31:0] mq[$];
   logic        m_run, m_done, m_ovf;
   logic [31:0] m_base;
   logic [15:0] m_nw, m_written;
   logic [31:0] hs_addr[$];
   int          hs_cnt;
   logic        saw_valid;

   typedef struct {
      logic        st;
      logic [31:0] b;
      logic [15:0] n;
      logic        push;
      logic [31:0] d;
      logic        exp_vld;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic        exp_done;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_run = 1'b0;
      m_done = 1'b0;
      m_ovf = 1'b0;
      m_base = '0;
      m_nw = '0;
      m_written = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_valid"}, wr_if.wr_valid, 0);
      chk({tag, "_wr_addr"}, wr_if.wr_addr, 0);
      chk({tag, "_wr_data"}, wr_if.wr_data, 0);
      chk({tag, "_fifo_full"}, fifo_full, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // Called at a falling edge: drive inputs, check outputs against the model, advance one clock.
   task automatic step(input logic st, input logic [31:0] b, input logic [15:0] n,
                       input logic push, input logic [31:0] d, input logic rdy);
      logic exp_vld;
      logic pop;
      logic full_before;
      start = st;
      base = b;
      num_words = n;
      out_storage_wr_en = push;
      psum_in = d;
      wr_if.wr_ready = rdy;
      #1;
      exp_vld = m_run && (mq.size() > 0);
      chk("wr_valid", wr_if.wr_valid, exp_vld);
      if (exp_vld) begin
         chk("wr_addr", wr_if.wr_addr, m_base + 32'(m_written) * 4);
         chk("wr_data", wr_if.wr_data, mq[0]);
      end
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_done);
      if (wr_if.wr_valid) saw_valid = 1'b1;
      pop = exp_vld && rdy;
      if (pop && !st) begin
         hs_cnt++;
         hs_addr.push_back(wr_if.wr_addr);
      end
      @(posedge CLK);
      if (st) begin
         mq.delete();
         m_ovf = 1'b0;
         m_written = '0;
         m_base = b;
         m_nw = n;
         m_run = 1'b1;
         m_done = 1'b0;
      end else if (m_run) begin
         full_before = (mq.size() == DEPTH);
         if (pop) begin
            void'(mq.pop_front());
            m_written++;
         end
         if (push) begin
            if (!full_before || pop) mq.push_back(d);
            else m_ovf = 1'b1;
         end
         if ((m_nw == 0) || (pop && (m_written == m_nw))) begin
            m_run = 1'b0;
            m_done = 1'b1;
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      int          pushed;
      logic        p;
      logic        rdy;
      logic        prev_stall;
      logic [31:0] prev_addr;
      logic [31:0] prev_data;
      logic [15:0] n;
      logic [31:0] b;

      vt[0] = '{1'b1, 32'h1000, 16'd4, 1'b0, 32'h0, 1'b0, 32'h0,    32'h0, 1'b0};
      vt[1] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hA, 1'b0, 32'h0,    32'h0, 1'b0};
      vt[2] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hB, 1'b1, 32'h1000, 32'hA, 1'b0};
      vt[3] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hC, 1'b1, 32'h1004, 32'hB, 1'b0};
      vt[4] = '{1'b0, 32'h0,    16'd0, 1'b1, 32'hD, 1'b1, 32'h1008, 32'hC, 1'b0};
      vt[5] = '{1'b0, 32'h0,    16'd0, 1'b0, 32'h0, 1'b1, 32'h100C, 32'hD, 1'b0};
      vt[6] = '{1'b0, 32'h0,    16'd0, 1'b0, 32'h0, 1'b0, 32'h0,    32'h0, 1'b1};
      vt[7] = '{1'b0, 32'h0,    16'd0, 1'b0, 32'h0, 1'b0, 32'h0,    32'h0, 1'b1};

      model_reset();
      hs_cnt = 0;
      saw_valid = 1'b0;
      wr_if.wr_ready = 1'b0;
      RESETN = 1'b0;
      repeat (2) @(negedge CLK);
      chk_reset_outputs("reset");
      RESETN = 1'b1;
      @(negedge CLK);

      // Basic run from the vector table.
      for (int i = 0; i < 8; i++) begin
         chk("tbl_valid", wr_if.wr_valid, vt[i].exp_vld);
         if (vt[i].exp_vld) begin
            chk("tbl_addr", wr_if.wr_addr, vt[i].exp_addr);
            chk("tbl_data", wr_if.wr_data, vt[i].exp_data);
         end
         chk("tbl_done", done, vt[i].exp_done);
         step(vt[i].st, vt[i].b, vt[i].n, vt[i].push, vt[i].d, 1'b1);
      end

      // Random backpressure over 40 words.
      step(1'b1, 32'h2000, 16'd40, 1'b0, 32'h0, 1'b0);
      hs_cnt = 0;
      pushed = 0;
      prev_stall = 1'b0;
      prev_addr = '0;
      prev_data = '0;
      for (int c = 0; c < 800 && !m_done; c++) begin
         if (prev_stall) begin
            chk("stall_addr", wr_if.wr_addr, prev_addr);
            chk("stall_data", wr_if.wr_data, prev_data);
         end
         p = (pushed < 40) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 1) == 1);
         prev_stall = wr_if.wr_valid && !rdy;
         prev_addr = wr_if.wr_addr;
         prev_data = wr_if.wr_data;
         if (p) pushed++;
         step(1'b0, 32'h0, 16'd0, p, $urandom, rdy);
      end
      chk("bp_done", done, 1);
      chk("bp_count", hs_cnt, 40);
      chk("bp_overflow", overflow, 0);

      // Fill to 16, drop the 17th, then drain.
      step(1'b1, 32'h3000, 16'd20, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 16'd0, 1'b1, 32'h100 + i, 1'b0);
      chk("full_after16", fifo_full, 1);
      chk("ovf_after16", overflow, 0);
      step(1'b0, 32'h0, 16'd0, 1'b1, 32'hDEAD, 1'b0);
      chk("ovf_after17", overflow, 1);
      chk("full_after17", fifo_full, 1);
      hs_cnt = 0;
      repeat (30) step(1'b0, 32'h0, 16'd0, 1'b0, 32'h0, 1'b1);
      chk("drain_count", hs_cnt, 16);
      chk("drain_not_done", done, 0);

      // Push into a full FIFO while the head is popped.
      step(1'b1, 32'h4000, 16'd40, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 16'd0, 1'b1, 32'h200 + i, 1'b0);
      chk("fp_full_before", fifo_full, 1);
      hs_cnt = 0;
      step(1'b0, 32'h0, 16'd0, 1'b1, 32'hBEEF, 1'b1);
      chk("fp_overflow", overflow, 0);
      chk("fp_full_after", fifo_full, 1);
      repeat (20) step(1'b0, 32'h0, 16'd0, 1'b0, 32'h0, 1'b1);
      chk("fp_count", hs_cnt, 17);

      // Zero-length job.
      step(1'b1, 32'h5000, 16'd0, 1'b0, 32'h0, 1'b1);
      saw_valid = 1'b0;
      repeat (5) step(1'b0, 32'h0, 16'd0, 1'b1, $urandom, 1'b1);
      chk("zero_done", done, 1);
      chk("zero_no_valid", saw_valid, 0);

      // Address wrap at the top of memory.
      hs_addr.delete();
      step(1'b1, 32'hFFFF_FFFC, 16'd2, 1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 16'd0, 1'b1, 32'h11, 1'b1);
      step(1'b0, 32'h0, 16'd0, 1'b1, 32'h22, 1'b1);
      repeat (3) step(1'b0, 32'h0, 16'd0, 1'b0, 32'h0, 1'b1);
      chk("wrap_count", hs_addr.size(), 2);
      if (hs_addr.size() >= 2) begin
         chk("wrap_addr0", hs_addr[0], 32'hFFFF_FFFC);
         chk("wrap_addr1", hs_addr[1], 32'h0000_0000);
      end
      chk("wrap_done", done, 1);

      // Asynchronous reset with words queued, then restart.
      step(1'b1, 32'h6000, 16'd10, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 16'd0, 1'b1, 32'h300 + i, 1'b0);
      chk("prereset_valid", wr_if.wr_valid, 1);
      #2;
      RESETN = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      model_reset();
      @(negedge CLK);
      RESETN = 1'b1;
      hs_addr.delete();
      hs_cnt = 0;
      step(1'b1, 32'h7000, 16'd3, 1'b0, 32'h0, 1'b1);
      chk("restart_valid", wr_if.wr_valid, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 16'd0, 1'b1, 32'h400 + i, 1'b1);
      repeat (3) step(1'b0, 32'h0, 16'd0, 1'b0, 32'h0, 1'b1);
      chk("restart_count", hs_cnt, 3);
      if (hs_addr.size() >= 1) chk("restart_addr0", hs_addr[0], 32'h7000);
      chk("restart_done", done, 1);

      // Random traffic, including overflow and restarts mid-run.
      for (int r = 0; r < 6; r++) begin
         n = 16'($urandom_range(1, 30));
         b = $urandom & 32'hFFFF_FFFC;
         step(1'b1, b, n, 1'b0, 32'h0, 1'b0);
         for (int c = 0; c < 80; c++) begin
            step(1'b0, 32'h0, 16'd0, ($urandom_range(0, 3) != 0), $urandom,
                 ($urandom_range(0, 2) != 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
